his_pass_scheduler: RTL and testbench
=====================================

// Module: his_pass_scheduler
// PURPOSE
//  Sequences the shared histogram builder through one frame: RAM clear, coarse-histogram (CH) pass,
//  drain, clear, fine-histogram (FH) pass, drain. Pulls timestamps from PIXELS per-pixel TDC queues in
//  strict pixel order (0..PIXELS-1, one per pixel per acquisition), drives the builder's write strobe,
//  data and pass select, and skips stalled pixels by timeout.
// PARAMETERS
//  NP        16   timestamp width (matches `Np)
//  PIXELS    4    pixels sharing one builder (matches `PIXEL_NUM_PER_RAM)
//  ACQ_NUM   16   acquisitions per pass
//  TIMEOUT   64   cycles to wait on a silent pixel before skipping it
//  DRAIN     4    cycles after last write before the pass is considered closed (builder pipeline)
// PORTS
//  clk        in   1            clock
//  res        in   1            asynchronous reset, active-high
//  start      in   1            frame request, sampled in IDLE only
//  abort      in   1            synchronous abort, any state -> IDLE
//  req        in   PIXELS       pixel p has a timestamp available
//  ts         in   PIXELS*NP    timestamps, pixel p at [p*NP +: NP]
//  gnt        out  PIXELS       one-hot pop to pixel queue (combinational)
//  wr_en      out  1            builder write strobe (registered)
//  wr_data    out  NP           builder timestamp (registered)
//  wr_miss    out  1            qualifies wr_en: skipped pixel, wr_data = 0
//  pass       out  1            0 = CH pass, 1 = FH pass (builder hisNum)
//  clr        out  1            one-cycle builder RAM clear request
//  clr_done   in   1            builder clear complete (level or pulse)
//  busy       out  1            high in every state except IDLE
//  frame_done out  1            one-cycle pulse on completion of FH drain
//  miss_cnt   out  8            skipped slots this frame, saturating at 255
// BEHAVIOUR
//  Reset (res=1, async): state IDLE; gnt=0, wr_en=0, wr_data=0, wr_miss=0, pass=0, clr=0, busy=0,
//   frame_done=0, miss_cnt=0, pixel ptr=0, acq count=0, timeout count=0. Mid-frame reset discards all.
//  States: IDLE -> CLR_CH -> ACQ -> DRAIN -> CLR_FH -> ACQ -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 -> CLR_CH, clr pulses in the entry cycle, pass<=0, miss_cnt<=0.
//  CLR_CH/CLR_FH: clr high for exactly the first cycle; wait for clr_done=1 (may equal the clr cycle+1
//   at earliest; clr_done in the clr cycle is ignored) -> ACQ with ptr=0, acq=0, timeout=0.
//  ACQ: gnt[ptr] = req[ptr] (all other gnt bits 0). On gnt: next cycle wr_en=1, wr_data=ts[ptr],
//   wr_miss=0. If req[ptr]=0 for TIMEOUT consecutive cycles: next cycle wr_en=1, wr_miss=1, wr_data=0,
//   miss_cnt+1 (saturate), gnt stays 0. Either event advances: timeout<=0, ptr+1; ptr wrap to 0
//   increments acq. On the slot with ptr=PIXELS-1 and acq=ACQ_NUM-1 -> DRAIN. Requests from pixels
//   other than ptr are never granted; at most one write per cycle; back-to-back writes allowed.
//  DRAIN: count DRAIN cycles, wr_en=0. After CH drain: pass<=1, -> CLR_FH (clr pulse).
//   After FH drain -> DONE.
//  DONE: frame_done=1 for one cycle, pass<=0, -> IDLE. start in DONE is ignored.
//  abort=1: -> IDLE next cycle, gnt=0 same cycle, wr_en=0 next cycle, pass<=0; miss_cnt held.
//   abort and start together in IDLE: abort wins.
//  Counters: ptr clog2(PIXELS) bits, acq clog2(ACQ_NUM)+1 bits, timeout clog2(TIMEOUT)+1 bits; no
//   counter exceeds its terminal value.
//  wr_en/wr_data latency: exactly 1 cycle after gnt or timeout decision.
// TESTING
//  1. Reset mid-ACQ -> all outputs at reset values immediately; start later runs a clean frame.
//  2. All req=1, PIXELS=4, ACQ_NUM=16, clr_done 2 cycles after clr -> 64 writes per pass, gnt order
//     0,1,2,3 repeating, pass=0 for first 64 and 1 for next 64, one frame_done, miss_cnt=0.
//  3. req[2] stuck 0 -> each pixel-2 slot waits 64 cycles then wr_miss=1 with wr_data=0; miss_cnt=32
//     after frame; pixels 3 and 0 never granted out of order.
//  4. req[1] high only while ptr=0 -> no gnt[1] until ptr=1; ts captured equals ts[1] at grant cycle.
//  5. abort during CLR_FH waiting for clr_done -> IDLE next cycle, pass=0, no frame_done, busy=0.
//  6. start held high through DONE -> new frame begins only after IDLE, frame_done pulses once per frame.

Source files
------------

// File: rtl/his_pass_scheduler.sv
// his_pass_scheduler
//   Drives the shared histogram builder through one frame in this order:
//   RAM clear, coarse-histogram (CH) pass, drain, RAM clear, fine-histogram
//   (FH) pass, drain. Timestamps are popped from the per-pixel TDC queues in
//   strict pixel order, one per pixel per acquisition. A pixel that stays
//   silent for TIMEOUT cycles is skipped, and a qualified miss write is sent
//   in its place.
// Ports
//   clk, res        clock; asynchronous active-high reset
//   start           frame request (sampled in IDLE only)
//   abort           synchronous abort to IDLE from any state
//   req / ts        per-pixel timestamp available / timestamp bus (pixel p at [p*NP +: NP])
//   gnt             one-hot combinational pop to the pixel queue
//   wr_en/wr_data   registered builder write strobe and timestamp
//   wr_miss         qualifies wr_en: slot was skipped, wr_data = 0
//   pass            0 = CH pass, 1 = FH pass
//   clr / clr_done  one-cycle builder RAM clear request / clear complete
//   busy            high outside IDLE
//   frame_done      one-cycle pulse after the FH drain
//   miss_cnt        skipped slots this frame, saturating at 255
module his_pass_scheduler #(
  parameter int unsigned NP      = 16,
  parameter int unsigned PIXELS  = 4,
  parameter int unsigned ACQ_NUM = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned DRAIN   = 4
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PIXELS-1:0]    req,
  input  logic [PIXELS*NP-1:0] ts,
  output logic [PIXELS-1:0]    gnt,
  output logic                 wr_en,
  output logic [NP-1:0]        wr_data,
  output logic                 wr_miss,
  output logic                 pass,
  output logic                 clr,
  input  logic                 clr_done,
  output logic                 busy,
  output logic                 frame_done,
  output logic [7:0]           miss_cnt
);

  localparam int unsigned PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int unsigned AW = $clog2(ACQ_NUM) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam int unsigned DW = $clog2(DRAIN) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR_CH, S_ACQ, S_DRAIN, S_CLR_FH, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_ptr;
  logic [AW-1:0]     r_acq;
  logic [TW-1:0]     r_to;
  logic [DW-1:0]     r_drn;
  logic              r_clr, r_pass, r_wr_en, r_wr_miss;
  logic [NP-1:0]     r_wr_data;
  logic [7:0]        r_miss;
  logic [PIXELS-1:0] w_gnt;
  logic              w_adv, w_tmo, w_last;
  logic [NP-1:0]     w_sel_ts;

  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    w_adv       = 1'b0;
    w_tmo       = 1'b0;
    w_sel_ts    = ts[r_ptr*NP +: NP];
    w_last      = (r_ptr == PW'(PIXELS-1)) && (r_acq == AW'(ACQ_NUM-1));
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_CLR_CH;
      // clr_done coinciding with the clr cycle belongs to an older request
      S_CLR_CH,
      S_CLR_FH: if (!r_clr && clr_done) w_state_nxt = S_ACQ;
      S_ACQ: begin
        if (req[r_ptr]) begin
          w_gnt[r_ptr] = 1'b1;
          w_adv        = 1'b1;
        end else if (r_to == TW'(TIMEOUT-1)) begin
          w_tmo = 1'b1;
          w_adv = 1'b1;
        end
        if (w_adv && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN:  if (r_drn == DW'(DRAIN-1)) w_state_nxt = r_pass ? S_DONE : S_CLR_FH;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_gnt       = '0;
      w_adv       = 1'b0;
      w_tmo       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_ptr     <= '0;
      r_acq     <= '0;
      r_to      <= '0;
      r_drn     <= '0;
      r_clr     <= 1'b0;
      r_pass    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_miss <= 1'b0;
      r_wr_data <= '0;
      r_miss    <= '0;
    end else begin
      r_wr_en   <= w_adv;
      r_wr_miss <= w_tmo;
      if (w_adv) r_wr_data <= w_tmo ? '0 : w_sel_ts;
      if (w_tmo && r_miss != 8'hFF) r_miss <= r_miss + 8'd1;

      r_clr <= 1'b0;
      if (r_state == S_IDLE && w_state_nxt == S_CLR_CH) begin
        r_clr  <= 1'b1;
        r_pass <= 1'b0;
        r_miss <= '0;
      end
      if (r_state == S_DRAIN && w_state_nxt == S_CLR_FH) begin
        r_clr  <= 1'b1;
        r_pass <= 1'b1;
      end
      if (w_state_nxt == S_IDLE) r_pass <= 1'b0;

      // Slot counters run only while staying in ACQ; any entry or exit restarts them at zero.
      if (r_state != S_ACQ || w_state_nxt != S_ACQ) begin
        r_ptr <= '0;
        r_acq <= '0;
        r_to  <= '0;
      end else if (w_adv) begin
        r_to <= '0;
        if (r_ptr == PW'(PIXELS-1)) begin
          r_ptr <= '0;
          r_acq <= r_acq + AW'(1);
        end else begin
          r_ptr <= r_ptr + PW'(1);
        end
      end else begin
        r_to <= r_to + TW'(1);
      end

      if (r_state == S_DRAIN && w_state_nxt == S_DRAIN) r_drn <= r_drn + DW'(1);
      else                                              r_drn <= '0;
    end
  end

  assign gnt        = w_gnt;
  assign wr_en      = r_wr_en;
  assign wr_data    = r_wr_data;
  assign wr_miss    = r_wr_miss;
  assign pass       = r_pass;
  assign clr        = r_clr;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign miss_cnt   = r_miss;

endmodule

// File: tb/tb_his_pass_scheduler.sv
// Directed bench for his_pass_scheduler with default parameters
// (PIXELS=4, ACQ_NUM=16, TIMEOUT=64, DRAIN=4). Inputs change on the falling
// edge; outputs are sampled 1 ns later.
module tb_his_pass_scheduler;

  localparam int NP = 16;
  localparam int PIXELS = 4;
  localparam int ACQ_NUM = 16;
  localparam int TIMEOUT = 64;
  localparam int SLOTS = PIXELS * ACQ_NUM;

  logic                 clk = 1'b0;
  logic                 res = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [PIXELS-1:0]    req = '0;
  logic [PIXELS*NP-1:0] ts = '0;
  logic [PIXELS-1:0]    gnt;
  logic                 wr_en;
  logic [NP-1:0]        wr_data;
  logic                 wr_miss;
  logic                 pass;
  logic                 clr;
  logic                 clr_done = 1'b0;
  logic                 busy;
  logic                 frame_done;
  logic [7:0]           miss_cnt;

  int checks = 0;
  int failures = 0;

  his_pass_scheduler #(.NP(NP), .PIXELS(PIXELS), .ACQ_NUM(ACQ_NUM), .TIMEOUT(TIMEOUT), .DRAIN(4)) dut (
    .clk(clk), .res(res), .start(start), .abort(abort), .req(req), .ts(ts),
    .gnt(gnt), .wr_en(wr_en), .wr_data(wr_data), .wr_miss(wr_miss), .pass(pass),
    .clr(clr), .clr_done(clr_done), .busy(busy), .frame_done(frame_done), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_wr_miss"}, 32'(wr_miss), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_clr"}, 32'(clr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_miss_cnt"}, 32'(miss_cnt), 0);
  endtask

  // Runs one frame. The bench tracks the expected slot sequence (pixel
  // 0..3 repeating) on its own. mode 0: every pixel always ready.
  // mode 1: pixel 2 is never ready. mode 2: pixel 0 is ready only every
  // third cycle, while pixel 1 is ready early.
  task automatic run_frame(input int mode, input bit hold_start, input bit stop_at_clr2,
                           input int exp_miss);
    int m_ptr = 0;
    int nwr = 0;
    int nfd = 0;
    int nclr = 0;
    int clrdly = 0;
    int last_dec = 0;
    bit pend_valid = 0;
    logic [NP-1:0] pend_data = '0;
    bit prev_clr = 0;
    bit done = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      clr_done = (clrdly == 1);
      if (clrdly > 0) clrdly--;
      for (int p = 0; p < PIXELS; p++) begin
        ts[p*NP +: NP] = NP'((p << 12) | (cyc & 'hFFF));
        case (mode)
          1:       req[p] = (p != 2);
          2:       req[p] = (p == 0) ? ((cyc % 3) == 2) : 1'b1;
          default: req[p] = 1'b1;
        endcase
      end
      #1;
      if (wr_en) begin
        if (wr_miss) begin
          chk("miss_pixel", 32'(m_ptr), 2);
          chk("miss_gap", 32'(cyc - last_dec), TIMEOUT + 1);
          chk("miss_data", 32'(wr_data), 0);
          m_ptr = (m_ptr + 1) % PIXELS;
          last_dec = cyc - 1;
        end else begin
          chk("wr_pending", 32'(pend_valid), 1);
          chk("wr_data", 32'(wr_data), 32'(pend_data));
        end
        chk("wr_pass", 32'(pass), (nwr >= SLOTS) ? 1 : 0);
        nwr++;
      end else if (pend_valid) begin
        chk("wr_latency", 32'(wr_en), 1);
      end
      pend_valid = 0;
      if (gnt !== '0) begin
        chk("gnt_order", 32'(gnt), 32'(1 << m_ptr));
        chk("gnt_req", 32'(req[m_ptr]), 1);
        pend_valid = 1;
        pend_data = ts[m_ptr*NP +: NP];
        m_ptr = (m_ptr + 1) % PIXELS;
        last_dec = cyc;
      end
      if (clr) begin
        nclr++;
        chk("clr_one_cycle", 32'(prev_clr), 0);
        chk("clr_pass", 32'(pass), (nclr == 2) ? 1 : 0);
        if (stop_at_clr2 && nclr == 2) done = 1;
        else clrdly = 2;
      end
      prev_clr = clr;
      if (frame_done) begin
        nfd++;
        chk("fd_writes", 32'(nwr), 2 * SLOTS);
        done = 1;
      end
    end
    chk("frame_end_reached", 32'(done), 1);
    if (!stop_at_clr2) begin
      chk("frame_done_count", 32'(nfd), 1);
      chk("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
    end
  endtask

  initial begin
    int fd_cnt;
    int wr_cnt;
    // reset state
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    res = 1'b0;
    #1;
    chk_reset_outputs("post_reset");

    // all pixels ready: in-order grants, 64 writes per pass
    run_frame(0, 1'b0, 1'b0, 0);

    // pixel 2 stuck silent: every pixel-2 slot times out
    run_frame(1, 1'b0, 1'b0, 32);

    // reset in the middle of ACQ takes effect without a clock edge
    @(negedge clk);
    req = '1;
    clr_done = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("midacq_busy", 32'(busy), 1);
    chk("midacq_miss_cleared", 32'(miss_cnt), 0);
    #2;
    res = 1'b1;
    #1;
    chk_reset_outputs("midacq_reset");
    @(negedge clk);
    res = 1'b0;
    req = '0;
    clr_done = 1'b0;
    run_frame(0, 1'b0, 1'b0, 0);

    // pixel 1 ready early: no grant to it before its slot
    run_frame(2, 1'b0, 1'b0, 0);

    // abort while CLR_FH waits for clr_done
    run_frame(0, 1'b0, 1'b1, 0);
    @(negedge clk);
    clr_done = 1'b0;
    req = '0;
    #1;
    chk("abort_pre_busy", 32'(busy), 1);
    chk("abort_pre_pass", 32'(pass), 1);
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_gnt", 32'(gnt), 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pass", 32'(pass), 0);
    chk("abort_wr_en", 32'(wr_en), 0);
    fd_cnt = 0;
    wr_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      clr_done = (i == 2);
      #1;
      if (frame_done) fd_cnt++;
      if (wr_en) wr_cnt++;
    end
    chk("abort_no_frame_done", 32'(fd_cnt), 0);
    chk("abort_no_writes", 32'(wr_cnt), 0);
    chk("abort_stays_idle", 32'(busy), 0);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("abort_start_busy", 32'(busy), 0);
    chk("abort_start_clr", 32'(clr), 0);

    // start held high through DONE: next frame only after IDLE
    run_frame(0, 1'b1, 1'b0, 0);
    @(negedge clk);
    #1;
    chk("hold_idle_busy", 32'(busy), 0);
    chk("hold_idle_frame_done", 32'(frame_done), 0);
    @(negedge clk);
    #1;
    chk("hold_restart_busy", 32'(busy), 1);
    chk("hold_restart_clr", 32'(clr), 1);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("final_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
